// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer rectangle-fill engine.
package fb_pkg;

    localparam int FB_WIDTH  = 128;
    localparam int FB_HEIGHT = 96;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2,
        S_DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/fb_clip.sv
// Clips a rectangle's extents to the visible framebuffer area.
// Only instantiated when FB_FILL_CLIP_EN is defined.
module fb_clip #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 96,
    parameter int XW     = 8,
    parameter int YW     = 8
) (
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] h,
    output logic [XW-1:0] ext_w,
    output logic [YW-1:0] ext_h
);

    logic [XW:0] x_end;
    logic [XW:0] x_lim;
    logic [YW:0] y_end;
    logic [YW:0] y_lim;

    // Sums are one bit wider than the operands so the far edge never wraps.
    always_comb begin
        x_end = {1'b0, x0} + {1'b0, w};
        x_lim = (x_end > (XW+1)'(WIDTH)) ? (XW+1)'(WIDTH) : x_end;
        ext_w = '0;
        if ({1'b0, x0} < (XW+1)'(WIDTH))
            ext_w = XW'(x_lim - {1'b0, x0});

        y_end = {1'b0, y0} + {1'b0, h};
        y_lim = (y_end > (YW+1)'(HEIGHT)) ? (YW+1)'(HEIGHT) : y_end;
        ext_h = '0;
        if ({1'b0, y0} < (YW+1)'(HEIGHT))
            ext_h = YW'(y_lim - {1'b0, y0});
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: writes a solid colour into the framebuffer in raster order.
// Optional FB_FILL_CLIP_EN clips to the screen; otherwise off-screen commands are rejected.
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int DATA_W = 9,
    parameter int ADDR_W = $clog2(WIDTH*HEIGHT),
    localparam int XW    = $clog2(WIDTH) + 1,
    localparam int YW    = $clog2(HEIGHT) + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [XW-1:0]     cmd_x0,
    input  logic [XW-1:0]     cmd_w,
    input  logic [YW-1:0]     cmd_y0,
    input  logic [YW-1:0]     cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic              grant,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a pixel write transfers on a rising edge where wren && grant, and
    // address/data/wren stay frozen until that happens.

    fill_state_t       state;
    logic [XW-1:0]     x0_q, w_q, xcnt, eff_w, ext_w;
    logic [YW-1:0]     y0_q, h_q, ycnt, eff_h, ext_h;
    logic [DATA_W-1:0] color_q;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] base;
    logic              reject;
    logic              last_col, last_row;

    assign state_dbg = state;

    // y*WIDTH + x as a sum of shifted copies of y, one per set bit of WIDTH.
    function automatic logic [ADDR_W-1:0] row_start(input logic [YW-1:0] y,
                                                    input logic [XW-1:0] x);
        logic [ADDR_W-1:0] acc;
        acc = ADDR_W'(x);
        for (int i = 0; i < 32; i++) begin
            if (((WIDTH >> i) & 1) != 0)
                acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    assign base = row_start(y0_q, x0_q);

`ifdef FB_FILL_CLIP_EN
    fb_clip #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .XW     (XW),
        .YW     (YW)
    ) u_clip (
        .x0     (x0_q),
        .w      (w_q),
        .y0     (y0_q),
        .h      (h_q),
        .ext_w  (ext_w),
        .ext_h  (ext_h)
    );
    assign reject = 1'b0;
`else
    assign ext_w  = w_q;
    assign ext_h  = h_q;
    assign reject = (({1'b0, x0_q} + {1'b0, w_q}) > (XW+1)'(WIDTH)) ||
                    (({1'b0, y0_q} + {1'b0, h_q}) > (YW+1)'(HEIGHT));
`endif

    assign last_col = (({1'b0, xcnt} + (XW+1)'(1)) == {1'b0, eff_w});
    assign last_row = (({1'b0, ycnt} + (YW+1)'(1)) == {1'b0, eff_h});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wren      <= 1'b0;
            address   <= '0;
            data      <= '0;
            x0_q      <= '0;
            w_q       <= '0;
            y0_q      <= '0;
            h_q       <= '0;
            color_q   <= '0;
            xcnt      <= '0;
            ycnt      <= '0;
            eff_w     <= '0;
            eff_h     <= '0;
            row_base  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        x0_q      <= cmd_x0;
                        w_q       <= cmd_w;
                        y0_q      <= cmd_y0;
                        h_q       <= cmd_h;
                        color_q   <= cmd_color;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    xcnt     <= '0;
                    ycnt     <= '0;
                    eff_w    <= ext_w;
                    eff_h    <= ext_h;
                    row_base <= base;
                    address  <= base;
                    data     <= color_q;
                    if (reject || ext_w == '0 || ext_h == '0) begin
                        done  <= 1'b1;
                        err   <= reject;
                        state <= S_DONE;
                    end else begin
                        wren  <= 1'b1;
                        state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (grant) begin
                        if (last_col && last_row) begin
                            wren  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (last_col) begin
                            xcnt     <= '0;
                            ycnt     <= ycnt + 1'b1;
                            row_base <= row_base + ADDR_W'(WIDTH);
                            address  <= row_base + ADDR_W'(WIDTH);
                        end else begin
                            xcnt    <= xcnt + 1'b1;
                            address <= address + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    err       <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomized self-checking bench for fb_rect_fill against a raster-order write-list model.
module tb_fb_rect_fill;
    import fb_pkg::*;

    localparam int WIDTH  = 128;
    localparam int HEIGHT = 96;
    localparam int DATA_W = 9;
    localparam int ADDR_W = 14;
    localparam int XW     = 8;
    localparam int YW     = 8;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [XW-1:0]     cmd_x0, cmd_w;
    logic [YW-1:0]     cmd_y0, cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic              grant;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] exp_q[$];
    logic              exp_err;

    fb_rect_fill #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .DATA_W (DATA_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_w     (cmd_w),
        .cmd_y0    (cmd_y0),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the list of addresses a command should write, in raster order.
    task automatic build_expected(input int x0, input int w, input int y0, input int h);
        exp_q.delete();
        exp_err = 1'b0;
`ifdef FB_FILL_CLIP_EN
        for (int y = y0; y < y0 + h; y++)
            for (int x = x0; x < x0 + w; x++)
                if (x < WIDTH && y < HEIGHT)
                    exp_q.push_back(ADDR_W'(y * WIDTH + x));
`else
        if (x0 + w > WIDTH || y0 + h > HEIGHT) begin
            exp_err = 1'b1;
        end else begin
            for (int y = y0; y < y0 + h; y++)
                for (int x = x0; x < x0 + w; x++)
                    exp_q.push_back(ADDR_W'(y * WIDTH + x));
        end
`endif
    endtask

    function automatic logic [DATA_W-1:0] rand_color();
        pixel_t p;
        p.r = 3'($urandom_range(0, 7));
        p.g = 3'($urandom_range(0, 7));
        p.b = 3'($urandom_range(0, 7));
        return p;
    endfunction

    // gmode: 0 = grant always high, 1 = grant low on the first fill cycle then toggling, 2 = random.
    task automatic run_cmd(input int x0, input int w, input int y0, input int h,
                           input logic [DATA_W-1:0] color, input int gmode, output int lat);
        int   cyc, stalls, nexp;
        logic stalled, g, fin;
        logic [ADDR_W-1:0] held_a;
        build_expected(x0, w, y0, h);
        nexp    = exp_q.size();
        lat     = 0;
        cyc     = 0;
        stalls  = 0;
        stalled = 1'b0;
        fin     = 1'b0;
        @(negedge clock);
        check_eq("ready_before_cmd", cmd_ready, 1);
        cmd_x0    = XW'(x0);
        cmd_w     = XW'(w);
        cmd_y0    = YW'(y0);
        cmd_h     = YW'(h);
        cmd_color = color;
        cmd_valid = 1'b1;
        grant     = 1'b0;
        @(posedge clock);
        #1;
        // Garbage on the command bus while busy must be ignored.
        cmd_x0    = XW'($urandom);
        cmd_w     = XW'($urandom);
        cmd_y0    = YW'($urandom);
        cmd_h     = YW'($urandom);
        cmd_color = DATA_W'($urandom);
        while (!fin && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            case (gmode)
                0:       g = 1'b1;
                1:       g = (cyc % 2 == 1);
                default: g = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                check_eq("stall_hold_addr", address, held_a);
                check_eq("stall_hold_wren", wren, 1);
            end
            stalled = 1'b0;
            if (done) begin
                cmd_valid = 1'b0;
                check_eq("err", err, exp_err);
                check_eq("missing_writes", exp_q.size(), 0);
                check_eq("latency", cyc, 2 + nexp + stalls);
                check_eq("wren_at_done", wren, 0);
                fin = 1'b1;
                lat = cyc;
            end else begin
                check_eq("busy", busy, 1);
                check_eq("ready_while_busy", cmd_ready, 0);
                check_eq("err_early", err, 0);
                if (wren) begin
                    check_eq("data", data, color);
                    if (g) begin
                        if (exp_q.size() == 0) check_eq("extra_write", address, 0 - 1);
                        else check_eq("addr", address, exp_q.pop_front());
                    end else begin
                        stalls++;
                        stalled = 1'b1;
                        held_a  = address;
                    end
                end
            end
            grant = g;
        end
        grant     = 1'b0;
        cmd_valid = 1'b0;
        if (!fin) begin
            check_eq("timeout_done", 0, 1);
        end else begin
            @(negedge clock);
            check_eq("ready_after_done", cmd_ready, 1);
            check_eq("busy_after_done", busy, 0);
            check_eq("done_pulse_len", done, 0);
        end
    endtask

    initial begin
        int lat;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_w     = '0;
        cmd_y0    = '0;
        cmd_h     = '0;
        cmd_color = '0;
        grant     = 1'b0;

        repeat (2) @(negedge clock);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_wren", wren, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_addr", address, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_state", state_dbg, 0);
        reset_n = 1'b1;

        run_cmd(3, 2, 5, 2, 9'h1C0, 0, lat);
        check_eq("lat_2x2_grant", lat, 6);
        run_cmd(3, 2, 5, 2, 9'h1C0, 1, lat);
        check_eq("lat_2x2_toggle", lat, 10);
        run_cmd(126, 4, 95, 2, 9'h0A5, 0, lat);
        run_cmd(10, 0, 4, 10, 9'h111, 0, lat);
        check_eq("lat_zero_w", lat, 2);
        run_cmd(20, 5, 7, 0, 9'h0FF, 0, lat);
        run_cmd(0, 128, 0, 96, 9'h1FF, 0, lat);
        check_eq("lat_full", lat, 2 + WIDTH * HEIGHT);
        run_cmd(127, 1, 95, 1, 9'h003, 2, lat);
        run_cmd(200, 3, 10, 3, 9'h055, 2, lat);

        for (int n = 0; n < 40; n++)
            run_cmd($urandom_range(0, 140), $urandom_range(0, 20), $urandom_range(0, 100),
                    $urandom_range(0, 10), rand_color(), 2, lat);

        // Reset in the middle of a fill abandons it without a done pulse.
        @(negedge clock);
        cmd_x0 = 8'd0; cmd_w = 8'd10; cmd_y0 = 8'd0; cmd_h = 8'd10;
        cmd_color = 9'h12A;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        grant     = 1'b1;
        repeat (20) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_wren", wren, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ready", cmd_ready, 1);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_addr", address, 0);
        repeat (3) begin
            @(negedge clock);
            check_eq("midrst_no_done", done, 0);
        end
        grant   = 1'b0;
        reset_n = 1'b1;

        run_cmd(5, 3, 2, 2, 9'h077, 2, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
